// File: rtl/stack_unit.sv
// LIFO stack for the CPU's PSH/POP instructions: register-array storage, a stack
// pointer, full/empty status and sticky overflow/underflow flags.
module stack_unit #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_enable,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_enable,
    output logic [WIDTH-1:0] pop_data,
    output logic [PW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clear
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    tail_idx_s;
    logic             empty_s, full_s;
    logic             set_ov_s, set_un_s;

    // DEPTH is a power of two, so the low count bits minus one wrap to the top slot when full.
    assign tail_idx_s = count_q[AW-1:0];
    assign top_idx_s  = count_q[AW-1:0] - AW'(1);
    assign empty_s    = (count_q == {PW{1'b0}});
    assign full_s     = (count_q == PW'(DEPTH));

    // Next-state decode for pointer, storage write port and sticky flags.
    always_comb begin
        count_d  = count_q;
        wr_en_s  = 1'b0;
        wr_idx_s = tail_idx_s;
        set_ov_s = 1'b0;
        set_un_s = 1'b0;
        case ({push_enable, pop_enable})
            2'b10: begin
                if (full_s) begin
                    set_ov_s = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                    count_d = count_q + PW'(1);
                end
            end
            2'b01: begin
                if (empty_s) begin
                    set_un_s = 1'b1;
                end else begin
                    count_d = count_q - PW'(1);
                end
            end
            2'b11: begin
                wr_en_s = 1'b1;
                if (empty_s) begin
                    set_un_s = 1'b1;
                    wr_idx_s = {AW{1'b0}};
                    count_d  = PW'(1);
                end else begin
                    wr_idx_s = top_idx_s;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        // A flag-setting event beats err_clear in the same cycle.
        if (set_ov_s) begin
            overflow_d = 1'b1;
        end else if (err_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (set_un_s) begin
            underflow_d = 1'b1;
        end else if (err_clear) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Stack pointer and sticky flags, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= {PW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= push_data;
        end
    end

    // Top-of-stack read, forced to zero when there is nothing to read.
    always_comb begin
        if (empty_s) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_q[top_idx_s];
        end
    end

    assign count     = count_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based reference stack predicts outputs,
// a monitor process compares them against the DUT.
module tb_stack_unit;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int PW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             push_enable;
    logic [WIDTH-1:0] push_data;
    logic             pop_enable;
    logic             err_clear;
    logic [WIDTH-1:0] pop_data;
    logic [PW-1:0]    count;
    logic             empty, full, overflow, underflow;

    stack_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_enable(push_enable),
        .push_data  (push_data),
        .pop_enable (pop_enable),
        .pop_data   (pop_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] pd;
        logic [PW-1:0]    cnt;
        logic             emp;
        logic             ful;
        logic             ov;
        logic             un;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: a plain queue used as a stack, plus two flag bits.
    logic [WIDTH-1:0] mdl[$];
    logic             m_ov, m_un;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.pd  = (mdl.size() > 0) ? mdl[mdl.size() - 1] : '0;
        e.cnt = PW'(mdl.size());
        e.emp = (mdl.size() == 0);
        e.ful = (mdl.size() == DEPTH);
        e.ov  = m_ov;
        e.un  = m_un;
        return e;
    endfunction

    task automatic model_step(input logic psh, input logic pp, input logic [WIDTH-1:0] d, input logic clr);
        logic ev_ov, ev_un;
        ev_ov = psh && !pp && (mdl.size() == DEPTH);
        ev_un = pp && (mdl.size() == 0);
        if (psh && pp) begin
            if (mdl.size() == 0) mdl.push_back(d);
            else mdl[mdl.size() - 1] = d;
        end else if (psh) begin
            if (mdl.size() < DEPTH) mdl.push_back(d);
        end else if (pp) begin
            if (mdl.size() > 0) void'(mdl.pop_back());
        end
        m_ov = ev_ov ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_un = ev_un ? 1'b1 : (clr ? 1'b0 : m_un);
    endtask

    // One clock of stimulus: drive at negedge, record the pre-edge expectation, advance the model.
    task automatic cycle(input string tag, input logic psh, input logic pp,
                         input logic [WIDTH-1:0] d, input logic clr);
        @(negedge clk);
        push_enable = psh;
        pop_enable  = pp;
        push_data   = d;
        err_clear   = clr;
        exp_q.push_back(predict());
        tag_q.push_back(tag);
        model_step(psh, pp, d, clr);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Reset between edges; the expectation is checked before the next clock edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n       = 1'b0;
        push_enable = 1'b0;
        pop_enable  = 1'b0;
        err_clear   = 1'b0;
        mdl.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        exp_q.push_back(predict());
        tag_q.push_back(tag);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compares each expectation 1ns after it is posted.
    initial begin
        exp_t  e;
        string t;
        forever begin
            wait (exp_q.size() > 0);
            #1;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".pop_data"},  32'(pop_data),  32'(e.pd));
            chk({t, ".count"},     32'(count),     32'(e.cnt));
            chk({t, ".empty"},     32'(empty),     32'(e.emp));
            chk({t, ".full"},      32'(full),      32'(e.ful));
            chk({t, ".overflow"},  32'(overflow),  32'(e.ov));
            chk({t, ".underflow"}, 32'(underflow), 32'(e.un));
            chk({t, ".count_range"}, 32'(count <= PW'(DEPTH)), 32'(1));
        end
    end

    initial begin
        int bias;
        rst_n       = 1'b0;
        push_enable = 1'b0;
        pop_enable  = 1'b0;
        push_data   = 8'h00;
        err_clear   = 1'b0;
        m_ov        = 1'b0;
        m_un        = 1'b0;
        #2;
        exp_q.push_back(predict());
        tag_q.push_back("reset");
        #20;
        rst_n = 1'b1;

        // Basic LIFO order.
        cycle("lifo_push", 1'b1, 1'b0, 8'h11, 1'b0);
        cycle("lifo_push", 1'b1, 1'b0, 8'h22, 1'b0);
        cycle("lifo_push", 1'b1, 1'b0, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) cycle("lifo_pop", 1'b0, 1'b1, 8'h00, 1'b0);
        idle("lifo_end");

        // Fill, overflow, drain.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 8'(i), 1'b0);
        cycle("ovf_push", 1'b1, 1'b0, 8'hAA, 1'b0);
        idle("ovf_after");
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        idle("drain_end");

        // Underflow and clear priority.
        cycle("unf_pop", 1'b0, 1'b1, 8'h00, 1'b0);
        idle("unf_after");
        cycle("err_clear", 1'b0, 1'b0, 8'h00, 1'b1);
        idle("clr_after");
        cycle("clr_and_unf", 1'b0, 1'b1, 8'h00, 1'b1);
        idle("clr_unf_after");
        cycle("clr_again", 1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous push+pop: middle, full, empty.
        cycle("pp_setup", 1'b1, 1'b0, 8'h11, 1'b0);
        cycle("pp_setup", 1'b1, 1'b0, 8'h22, 1'b0);
        cycle("pp_setup", 1'b1, 1'b0, 8'h55, 1'b0);
        cycle("pp_mid", 1'b1, 1'b1, 8'h77, 1'b0);
        idle("pp_mid_after");
        for (int i = 0; i < DEPTH - 3; i++) cycle("pp_fill", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        cycle("pp_full", 1'b1, 1'b1, 8'h66, 1'b0);
        idle("pp_full_after");
        for (int i = 0; i < DEPTH; i++) cycle("pp_drain", 1'b0, 1'b1, 8'h00, 1'b0);
        cycle("pp_empty", 1'b1, 1'b1, 8'h77, 1'b0);
        idle("pp_empty_after");

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) cycle("ar_push", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cycle("ar_flag", 1'b1, 1'b1, 8'h01, 1'b0);
        async_reset("async_rst");
        cycle("ar_push99", 1'b1, 1'b0, 8'h99, 1'b0);
        cycle("ar_pop99", 1'b0, 1'b1, 8'h00, 1'b0);
        idle("ar_end");

        // Randomized traffic with phases biased toward filling or draining.
        bias = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 400 == 0) bias = 20 + 30 * int'($urandom_range(0, 2));
            cycle("random",
                  1'($urandom_range(0, 99) < bias),
                  1'($urandom_range(0, 99) < (100 - bias)),
                  8'($urandom),
                  1'($urandom_range(0, 15) == 0));
        end
        idle("final");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO stack serving the CPU's PSH/POP instructions. It sits between the instruction decoder and the register file. The decoder drives `push_enable`/`push_data` and `pop_enable`, and reads `pop_data` combinationally in the same cycle it writes that value into a GPR. The block holds the storage, the stack pointer, full/empty status and sticky overflow/underflow error flags that the control logic can sample.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 2.
- `WIDTH`, 8: data width in bits; matches the GPR width.
- `PW`, $clog2(DEPTH+1): width of `count` (derived; do not override).

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `push_enable`  in  1  push `push_data` this cycle.
- `push_data`  in  WIDTH  value to push.
- `pop_enable`  in  1  pop the top entry this cycle.
- `pop_data`  out  WIDTH  current top of stack; combinational from `count` and storage.
- `count`  out  PW  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; set by a rejected push.
- `underflow`  out  1  sticky; set by a rejected pop.
- `err_clear`  in  1  synchronous clear of both sticky flags.

## Operation
- Storage is a WIDTH×DEPTH register array. It is not reset. Only `count` and the flags reset.
- `pop_data` = `mem[count-1]` when `!empty`; otherwise it is 0.
- `pop_data` is valid during the same cycle as `pop_enable`. The decoder captures it at the same edge that pops.
- Per-edge behaviour is decided by (`push_enable`, `pop_enable`, `empty`, `full`):
  - Push only, not full: `mem[count] <= push_data`; `count` increments.
  - Push only, full: storage and `count` unchanged; `overflow` is set.
  - Pop only, not empty: `count` decrements. The popped entry is left in memory as stale data.
  - Pop only, empty: no change; `underflow` is set.
  - Push and pop, not empty (including full): replace the top.
    - `mem[count-1] <= push_data`; `count` is unchanged.
    - `pop_data` this cycle is the old top.
    - No flag is set.
  - Push and pop, empty:
    - The pop is rejected; `underflow` is set and `pop_data` is 0.
    - The push proceeds: `mem[0] <= push_data`, `count` becomes 1.
  - Neither enable: hold.
- Flag priority within one edge:
  - An event that sets a flag in the same cycle as `err_clear` takes precedence; the flag ends up 1.
  - Otherwise `err_clear` forces the flag to 0.
- Flags never affect data-path operation. Subsequent legal pushes and pops proceed while a flag is set.
- `count` arithmetic is unsigned PW bits. It never wraps, because the rejected cases above hold it.
- Storage is indexed with `count[$clog2(DEPTH)-1:0]`. Any index outside 0..DEPTH-1 is never written.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled at top level) drives:
  - `count` = 0, `empty` = 1, `full` = 0;
  - `overflow` = 0, `underflow` = 0;
  - `pop_data` = 0.
- Reset asserted mid-operation: `count` and the flags go to reset values immediately, with no clock needed. Storage contents become don't-care.
- Push latency is 1 cycle. A value pushed at edge N is visible on `pop_data` after edge N, before edge N+1.
- Pop latency is 0 cycles for data. `count`, `empty` and `full` update at the edge.
- Back-to-back operations are supported every cycle. There is no stall or ready signal, because the decoder issues at most one stack operation per instruction.
- Status outputs (`empty`, `full`, `count`, flags) are registered or derived directly from registered `count`. There is no combinational path from `push_enable`/`pop_enable` to any output. `pop_data` depends only on state.

## Test plan
- **Reset and basic LIFO.** Stimulus: reset, then push 0x11, 0x22, 0x33, then pop three times. Required response: pops return 0x33, 0x22, 0x11; `count` goes 3→0; `empty` = 1 at the end; no flags set.
- **Fill to full, then overflow.** Stimulus: push 0x00..0x0F (16 values), then push 0xAA. Required response: `full` = 1 and `count` = 16; `overflow` = 1; top remains 0x0F. The subsequent 16 pops return 0x0F..0x00.
- **Underflow, then clear.** Stimulus: pop on an empty stack. Required response: `pop_data` = 0, `underflow` = 1, `count` stays 0. Stimulus: assert `err_clear`. Required response: `underflow` = 0. Stimulus: `err_clear` together with another empty pop. Required response: `underflow` remains 1.
- **Simultaneous push+pop.** Stimulus: with 0x55 on top and `count` = 3, push 0x77 and pop in the same cycle. Required response: `pop_data` = 0x55 that cycle; after the edge the top is 0x77 and `count` = 3. Stimulus: repeat with the stack full. Required response: no overflow. Stimulus: repeat with the stack empty. Required response: `underflow` = 1, `count` = 1, top = 0x77.
- **Asynchronous reset mid-stream.** Stimulus: after 5 pushes, assert `rst_n` low between clock edges. Required response: `count` = 0, `empty` = 1 and the flags are 0 before the next edge. Stimulus: after release, push 0x99 and pop. Required response: the pop returns 0x99.
- **Randomized push/pop against a reference model.** Stimulus: 10k cycles of random push/pop with checks every cycle. Required response: `pop_data`, `count`, `full`, `empty` and both flags all match the model; `count` never leaves 0..16.
